subs_layer: RTL and testbench
=============================

Name: subs_layer

Overview:
- Substitution layer of the team's SPN block cipher datapath.
- Applies a 4-bit S-box to every nibble of the state word in parallel. The result is available combinationally with zero latency.
- Also provides a registered copy of the result for pipelined round logic.
- Sits between the key-addition stage and the permutation layer.

Parameters:
- SIZE, 64, state width in bits; must be a multiple of 4 (SIZE/4 S-box lanes).

Ports:
- clk  input  1  system clock, rising-edge active.
- reset  input  1  asynchronous, active-high reset; clears registered state only.
- original  input  SIZE  state word to be substituted.
- inverse  input  1  0 = forward S-box, 1 = inverse S-box (decryption). Tie to 0 for encryption.
- substituted  output  SIZE  combinational substitution of original.
- substituted_q  output  SIZE  registered copy of substituted.
- valid_q  output  1  high when substituted_q holds a result captured since the last reset.

Behaviour:
- Lane i covers bits [4i+3:4i], for i = 0..SIZE/4-1. Lanes are independent; no carries or cross-lane mixing.
- Forward S-box, indexed by input nibble 0..F: C 5 6 B 9 0 A D 3 E F 8 4 7 1 2.
- Inverse S-box, indexed by input nibble 0..F: 5 E F 8 C 1 2 D B 4 6 3 0 7 9 A.
- substituted:
  - Purely combinational from original and inverse.
  - Zero cycle latency; must settle within half a clock period.
  - Independent of clk and reset; valid even while reset is asserted.
  - An X/Z nibble on original may yield X on that lane only.
- substituted_q:
  - On each rising clk edge with reset low, captures substituted.
  - Latency of 1 cycle relative to original.
- valid_q:
  - Goes high on the first rising edge after reset deasserts.
  - Stays high until the next reset.
- Reset:
  - Asserting reset drives substituted_q to 0 and valid_q to 0 immediately, independent of clk, including mid-operation.
  - Release is synchronised by the first clk edge.
- Changing inverse between cycles is legal:
  - The combinational output follows immediately.
  - substituted_q reflects the mode sampled at the capturing edge.
- Round-trip invariant: inverse=1 applied to the forward output returns the original word, for every value.
- No handshake and no back-pressure; a new word may be accepted every cycle.

Test Plan:
- SIZE=64, inverse=0, original=0000000000000000 -> substituted=CCCCCCCCCCCCCCCC within 4 ns of applying the input.
- inverse=0, original=0123456789ABCDEF -> substituted=C56B90AD3EF84712. original=FFFFFFFFFFFFFFFF -> 2222222222222222.
- inverse=1, original=C56B90AD3EF84712 -> substituted=0123456789ABCDEF. Also sweep all 16 nibble values in every lane and check that forward followed by inverse is the identity.
- Registered path: drive 0123456789ABCDEF before edge N -> substituted_q=C56B90AD3EF84712 and valid_q=1 after edge N. Drive a new value each cycle and check a 1-cycle lag throughout.
- Assert reset asynchronously between edges while substituted_q is nonzero -> substituted_q=0 and valid_q=0 without waiting for an edge. substituted keeps tracking original during reset.
- Run the file-driven vector set of {original, expected} pairs at 10 ns period, checking at the falling edge -> 0 errors reported at the end of the vector set.

Source files
------------

// File: rtl/subs_layer.sv
// Substitution layer of the SPN cipher datapath: a 4-bit S-box on every nibble,
// with a zero-latency combinational result and a registered copy for pipelining.
module subs_layer #(
  parameter int SIZE = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [SIZE-1:0] original,
  input  logic            inverse,
  output logic [SIZE-1:0] substituted,
  output logic [SIZE-1:0] substituted_q,
  output logic            valid_q
);

  localparam int LANES = SIZE / 4;

  function automatic logic [3:0] sbox_fwd(input logic [3:0] n);
    case (n)
      4'h0: sbox_fwd = 4'hC;
      4'h1: sbox_fwd = 4'h5;
      4'h2: sbox_fwd = 4'h6;
      4'h3: sbox_fwd = 4'hB;
      4'h4: sbox_fwd = 4'h9;
      4'h5: sbox_fwd = 4'h0;
      4'h6: sbox_fwd = 4'hA;
      4'h7: sbox_fwd = 4'hD;
      4'h8: sbox_fwd = 4'h3;
      4'h9: sbox_fwd = 4'hE;
      4'hA: sbox_fwd = 4'hF;
      4'hB: sbox_fwd = 4'h8;
      4'hC: sbox_fwd = 4'h4;
      4'hD: sbox_fwd = 4'h7;
      4'hE: sbox_fwd = 4'h1;
      4'hF: sbox_fwd = 4'h2;
      default: sbox_fwd = 4'hx;
    endcase
  endfunction

  function automatic logic [3:0] sbox_inv(input logic [3:0] n);
    case (n)
      4'h0: sbox_inv = 4'h5;
      4'h1: sbox_inv = 4'hE;
      4'h2: sbox_inv = 4'hF;
      4'h3: sbox_inv = 4'h8;
      4'h4: sbox_inv = 4'hC;
      4'h5: sbox_inv = 4'h1;
      4'h6: sbox_inv = 4'h2;
      4'h7: sbox_inv = 4'hD;
      4'h8: sbox_inv = 4'hB;
      4'h9: sbox_inv = 4'h4;
      4'hA: sbox_inv = 4'h6;
      4'hB: sbox_inv = 4'h3;
      4'hC: sbox_inv = 4'h0;
      4'hD: sbox_inv = 4'h7;
      4'hE: sbox_inv = 4'h9;
      4'hF: sbox_inv = 4'hA;
      default: sbox_inv = 4'hx;
    endcase
  endfunction

  logic [SIZE-1:0] w_sub;
  logic [SIZE-1:0] r_sub_q;
  logic            r_valid_q;

  // Lanes are fully independent: an unknown nibble only corrupts its own lane.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign w_sub[4*i +: 4] = inverse ? sbox_inv(original[4*i +: 4])
                                     : sbox_fwd(original[4*i +: 4]);
  end

  // No handshake: a word is accepted on every edge; valid_q only marks that the
  // register has been loaded at least once since reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sub_q   <= '0;
      r_valid_q <= 1'b0;
    end else begin
      r_sub_q   <= w_sub;
      r_valid_q <= 1'b1;
    end
  end

  assign substituted   = w_sub;
  assign substituted_q = r_sub_q;
  assign valid_q       = r_valid_q;

endmodule

// File: tb/tb_subs_layer.sv
// Directed bench for subs_layer: combinational S-box, registered copy, async reset.
module tb_subs_layer;

  localparam int SIZE = 64;

  logic            clk;
  logic            reset;
  logic [SIZE-1:0] original;
  logic            inverse;
  logic [SIZE-1:0] substituted;
  logic [SIZE-1:0] substituted_q;
  logic            valid_q;

  int n_checks = 0;
  int n_errors = 0;

  logic [3:0] fwd_tab [16];
  logic [63:0] vec_in  [8];
  logic [63:0] vec_exp [8];

  subs_layer #(.SIZE(SIZE)) dut (
    .clk           (clk),
    .reset         (reset),
    .original      (original),
    .inverse       (inverse),
    .substituted   (substituted),
    .substituted_q (substituted_q),
    .valid_q       (valid_q)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    fwd_tab = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};
    vec_in[0] = 64'h0123456789ABCDEF; vec_exp[0] = 64'hC56B90AD3EF84712;
    vec_in[1] = 64'hFEDCBA9876543210; vec_exp[1] = 64'h21748FE3DA09B65C;
    vec_in[2] = 64'hDEADBEEFCAFEBABE; vec_exp[2] = 64'h71F781124F218F81;
    vec_in[3] = 64'h5555555555555555; vec_exp[3] = 64'h0000000000000000;
    vec_in[4] = 64'hA5A5A5A50F0F0F0F; vec_exp[4] = 64'hF0F0F0F0C2C2C2C2;
    vec_in[5] = 64'h123456789ABCDEF0; vec_exp[5] = 64'h56B90AD3EF84712C;
    vec_in[6] = 64'h0000000000000001; vec_exp[6] = 64'hCCCCCCCCCCCCCCC5;
    vec_in[7] = 64'h8000000000000000; vec_exp[7] = 64'h3CCCCCCCCCCCCCCC;
  end

  task automatic test_reset();
    reset    = 1'b1;
    inverse  = 1'b0;
    original = 64'h0;
    #4;
    n_checks++;
    if (substituted !== 64'hCCCCCCCCCCCCCCCC) begin
      n_errors++;
      $display("FAIL reset_comb: got %h expected %h", substituted, 64'hCCCCCCCCCCCCCCCC);
    end
    n_checks++;
    if (substituted_q !== 64'h0 || valid_q !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_state: got q=%h v=%b expected q=0 v=0", substituted_q, valid_q);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_checks++;
    if (valid_q !== 1'b0) begin
      n_errors++;
      $display("FAIL release_before_edge: got v=%b expected 0", valid_q);
    end
    @(posedge clk); #1;
    n_checks++;
    if (valid_q !== 1'b1 || substituted_q !== 64'hCCCCCCCCCCCCCCCC) begin
      n_errors++;
      $display("FAIL first_edge: got q=%h v=%b expected q=CCCCCCCCCCCCCCCC v=1",
               substituted_q, valid_q);
    end
  endtask

  task automatic test_forward();
    logic [63:0] ins  [3];
    logic [63:0] exps [3];
    ins[0] = 64'h0123456789ABCDEF; exps[0] = 64'hC56B90AD3EF84712;
    ins[1] = 64'hFFFFFFFFFFFFFFFF; exps[1] = 64'h2222222222222222;
    ins[2] = 64'h0000000000000000; exps[2] = 64'hCCCCCCCCCCCCCCCC;
    inverse = 1'b0;
    for (int k = 0; k < 3; k++) begin
      original = ins[k];
      #4;
      n_checks++;
      if (substituted !== exps[k]) begin
        n_errors++;
        $display("FAIL forward[%0d]: got %h expected %h", k, substituted, exps[k]);
      end
    end
  endtask

  task automatic test_inverse();
    logic [63:0] ins  [4];
    logic [63:0] exps [4];
    ins[0] = 64'hC56B90AD3EF84712; exps[0] = 64'h0123456789ABCDEF;
    ins[1] = 64'h21748FE3DA09B65C; exps[1] = 64'hFEDCBA9876543210;
    ins[2] = 64'hCCCCCCCCCCCCCCCC; exps[2] = 64'h0000000000000000;
    ins[3] = 64'h2222222222222222; exps[3] = 64'hFFFFFFFFFFFFFFFF;
    inverse = 1'b1;
    for (int k = 0; k < 4; k++) begin
      original = ins[k];
      #4;
      n_checks++;
      if (substituted !== exps[k]) begin
        n_errors++;
        $display("FAIL inverse[%0d]: got %h expected %h", k, substituted, exps[k]);
      end
    end
    inverse = 1'b0;
  endtask

  // Rotating nibble pattern so every lane sees every value across the 16 steps.
  task automatic test_roundtrip();
    logic [63:0] word;
    logic [63:0] fexp;
    for (int k = 0; k < 16; k++) begin
      for (int i = 0; i < 16; i++) begin
        word[4*i +: 4] = 4'((i + k) % 16);
        fexp[4*i +: 4] = fwd_tab[(i + k) % 16];
      end
      inverse  = 1'b0;
      original = word;
      #1;
      n_checks++;
      if (substituted !== fexp) begin
        n_errors++;
        $display("FAIL sweep_fwd[%0d]: got %h expected %h", k, substituted, fexp);
      end
      inverse  = 1'b1;
      original = fexp;
      #1;
      n_checks++;
      if (substituted !== word) begin
        n_errors++;
        $display("FAIL sweep_roundtrip[%0d]: got %h expected %h", k, substituted, word);
      end
    end
    inverse = 1'b0;
  endtask

  task automatic test_registered();
    @(negedge clk);
    inverse  = 1'b0;
    original = 64'h0123456789ABCDEF;
    @(posedge clk); #1;
    n_checks++;
    if (substituted_q !== 64'hC56B90AD3EF84712 || valid_q !== 1'b1) begin
      n_errors++;
      $display("FAIL registered: got q=%h v=%b expected q=C56B90AD3EF84712 v=1",
               substituted_q, valid_q);
    end
  endtask

  task automatic test_back_to_back();
    inverse = 1'b0;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      if (k > 0) begin
        n_checks++;
        if (substituted_q !== vec_exp[k-1]) begin
          n_errors++;
          $display("FAIL b2b_q[%0d]: got %h expected %h", k - 1, substituted_q, vec_exp[k-1]);
        end
      end
      if (k < 8) original = vec_in[k];
    end
  endtask

  task automatic test_mode_switch();
    @(negedge clk);
    inverse  = 1'b1;
    original = 64'hC56B90AD3EF84712;
    @(negedge clk);
    inverse  = 1'b0;
    original = 64'hFEDCBA9876543210;
    n_checks++;
    if (substituted_q !== 64'h0123456789ABCDEF) begin
      n_errors++;
      $display("FAIL mode_inv_q: got %h expected %h", substituted_q, 64'h0123456789ABCDEF);
    end
    @(negedge clk);
    n_checks++;
    if (substituted_q !== 64'h21748FE3DA09B65C) begin
      n_errors++;
      $display("FAIL mode_fwd_q: got %h expected %h", substituted_q, 64'h21748FE3DA09B65C);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    original = 64'h0123456789ABCDEF;
    inverse  = 1'b0;
    @(posedge clk); #2;
    n_checks++;
    if (substituted_q !== 64'hC56B90AD3EF84712) begin
      n_errors++;
      $display("FAIL pre_reset_q: got %h expected %h", substituted_q, 64'hC56B90AD3EF84712);
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if (substituted_q !== 64'h0 || valid_q !== 1'b0) begin
      n_errors++;
      $display("FAIL async_reset: got q=%h v=%b expected q=0 v=0", substituted_q, valid_q);
    end
    original = 64'hFFFFFFFFFFFFFFFF;
    #1;
    n_checks++;
    if (substituted !== 64'h2222222222222222) begin
      n_errors++;
      $display("FAIL comb_in_reset: got %h expected %h", substituted, 64'h2222222222222222);
    end
    @(posedge clk); #1;
    n_checks++;
    if (substituted_q !== 64'h0 || valid_q !== 1'b0) begin
      n_errors++;
      $display("FAIL hold_in_reset: got q=%h v=%b expected q=0 v=0", substituted_q, valid_q);
    end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (substituted_q !== 64'h2222222222222222 || valid_q !== 1'b1) begin
      n_errors++;
      $display("FAIL after_reset: got q=%h v=%b expected q=2222222222222222 v=1",
               substituted_q, valid_q);
    end
  endtask

  // Vector set: drive after the rising edge, check at the falling edge.
  task automatic test_vectors();
    inverse = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      original = vec_in[k];
      @(negedge clk);
      n_checks++;
      if (substituted !== vec_exp[k]) begin
        n_errors++;
        $display("FAIL vector[%0d]: got %h expected %h", k, substituted, vec_exp[k]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_forward();
    test_inverse();
    test_roundtrip();
    test_registered();
    test_back_to_back();
    test_mode_switch();
    test_async_reset();
    test_vectors();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
